apb_slave_mem: RTL and testbench

APB4 completer with a small word-addressed register memory, programmable wait-state insertion and error signalling. It sits directly downstream of the APB passthrough DUT, consuming its master-side bus (`m_*` signals) as the terminating slave. It gives the environment a cycle-accurate target with PREADY stalls, PSLVERR responses and byte-strobe writes.

---
 rtl/apb_slave_mem.sv | 138 +++++++++++++
 tb/tb_apb_slave_mem.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a small word-addressed register memory.
// Adds programmable wait states, error responses and byte-strobe writes.
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [7:0]            err_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PRIV_A  = ADDR_WIDTH'(4);
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            strb_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic                  s_err;
  logic [IW-1:0]         s_idx;
  logic                  setup;
  logic                  done;
  logic                  commit;
  logic                  unused_bits;

  assign unused_bits = ^pprot[2:1];

  // Decode the setup-phase address into a word index and an error flag.
  always_comb begin
    widx  = (paddr - BASE_ADDR) >> 2;
    s_idx = widx[IW-1:0];
    s_err = (paddr[1:0] != 2'b00)
         || (paddr < BASE_ADDR)
         || (widx >= DEPTH_A)
         || (pwrite && !pprot[0] && (widx < PRIV_A));
  end

  assign setup  = (state == IDLE) && psel && !penable;
  assign done   = (state == ACCESS) && psel && pready;
  assign commit = done && penable && wr_q && !err_q;

  // Transfer FSM: capture at setup, count wait states, complete or abort.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (setup) begin
            state   <= ACCESS;
            cnt     <= WAIT_C;
            wr_q    <= pwrite;
            err_q   <= s_err;
            idx_q   <= s_idx;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            if (WAIT_CYCLES == 0) begin
              pready  <= 1'b1;
              pslverr <= s_err;
              prdata  <= (!pwrite && !s_err) ? mem[s_idx] : '0;
            end
          end
        end
        ACCESS: begin
          if (!psel || pready) begin
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            if (done && penable && err_q && (err_cnt != 8'hFF))
              err_cnt <= err_cnt + 8'd1;
          end else begin
            if (cnt != 4'd0)
              cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= err_q;
              prdata  <= (!wr_q && !err_q) ? mem[idx_q] : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word storage: cleared by reset, byte-strobed writes at completion.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++)
        if (strb_q[b])
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with two wait states,
// a second zero-wait instance for back-to-back and saturation runs.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel_a, psel_b;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic        pready_a, pslverr_a;
  logic [31:0] prdata_a;
  logic [7:0]  err_cnt_a;
  logic        pready_b, pslverr_b;
  logic [31:0] prdata_b;
  logic [7:0]  err_cnt_b;

  int total = 0;
  int bad   = 0;
  int leaks = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.WAIT_CYCLES(2)) dut (
    .pclk(pclk), .preset(preset), .psel(psel_a),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_a), .pslverr(pslverr_a),
    .prdata(prdata_a), .err_cnt(err_cnt_a)
  );

  apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel_b),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_b), .pslverr(pslverr_b),
    .prdata(prdata_b), .err_cnt(err_cnt_b)
  );

  task automatic xfer(
    input  int          w,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  logic [2:0]  p,
    output logic [31:0] rd,
    output logic        err,
    output int          n
  );
    logic rdy;
    logic got;
    @(negedge pclk);
    psel_a  = (w == 0);
    psel_b  = (w == 1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    pprot   = p;
    @(negedge pclk);
    penable = 1'b1;
    n   = 1;
    rd  = '0;
    err = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rdy = (w == 1) ? pready_b : pready_a;
      if (rdy) begin
        rd  = (w == 1) ? prdata_b : prdata_a;
        err = (w == 1) ? pslverr_b : pslverr_a;
        got = 1'b1;
        break;
      end
      if ((w == 1) ? (pslverr_b !== 1'b0 || prdata_b !== 32'h0)
                   : (pslverr_a !== 1'b0 || prdata_a !== 32'h0))
        leaks++;
      @(negedge pclk);
      n++;
    end
    if (!got) begin
      n = -1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    preset  = 1'b1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    repeat (3) @(negedge pclk);
    total++;
    if (pready_a !== 1'b0) begin
      bad++; $display("FAIL rst_pready got=%b exp=0", pready_a);
    end
    total++;
    if (pslverr_a !== 1'b0 || prdata_a !== 32'h0) begin
      bad++;
      $display("FAIL rst_out got=%b/%h exp=0/0", pslverr_a, prdata_a);
    end
    total++;
    if (err_cnt_a !== 8'd0 || err_cnt_b !== 8'd0) begin
      bad++;
      $display("FAIL rst_errcnt got=%0d/%0d exp=0/0", err_cnt_a, err_cnt_b);
    end
    preset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        err;
    int          n;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd1, rd, err, n);
    total++;
    if (n !== 3 || err !== 1'b0) begin
      bad++; $display("FAIL basic_wr got=n%0d e%b exp=n3 e0", n, err);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL basic_rd_len got=%0d exp=3", n);
    end
    total++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      bad++; $display("FAIL basic_rd got=%h e%b exp=deadbeef e0", rd, err);
    end
    idle();
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic        err;
    int          n;
    xfer(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 3'd1, rd, err, n);
    xfer(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 3'd1, rd, err, n);
    xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'h11BB33DD) begin
      bad++; $display("FAIL strobe got=%h exp=11bb33dd", rd);
    end
    xfer(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 3'd1, rd, err, n);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL strb0_err got=%b exp=0", err);
    end
    xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'h11BB33DD) begin
      bad++; $display("FAIL strb0 got=%h exp=11bb33dd", rd);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        err;
    int          n;
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL err_oob got=e%b %h exp=e1 0", err, rd);
    end
    xfer(0, 1'b1, 32'h12, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_unal got=%b exp=1", err);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      bad++; $display("FAIL unal_keep got=%h e%b exp=deadbeef e0", rd, err);
    end
    xfer(0, 1'b1, 32'h04, 32'h5, 4'hF, 3'd0, rd, err, n);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_priv got=%b exp=1", err);
    end
    xfer(0, 1'b1, 32'h04, 32'h5, 4'hF, 3'd1, rd, err, n);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL priv_ok got=%b exp=0", err);
    end
    idle();
    total++;
    if (err_cnt_a !== 8'd3) begin
      bad++; $display("FAIL err_cnt got=%0d exp=3", err_cnt_a);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        err;
    int          n;
    int          seen;
    xfer(0, 1'b1, 32'h18, 32'h55AA55AA, 4'hF, 3'd1, rd, err, n);
    idle();
    @(negedge pclk);
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h18;
    pwdata  = 32'h12345678;
    pstrb   = 4'hF;
    pprot   = 3'd1;
    @(negedge pclk);
    psel_a  = 1'b0;
    penable = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pclk);
      if (pready_a === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abort_rdy got=%0d exp=0", seen);
    end
    xfer(0, 1'b0, 32'h18, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'h55AA55AA) begin
      bad++; $display("FAIL abort_mem got=%h exp=55aa55aa", rd);
    end
    idle();
    total++;
    if (err_cnt_a !== 8'd3) begin
      bad++; $display("FAIL abort_cnt got=%0d exp=3", err_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          n;
    @(negedge pclk);
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h1C;
    pwdata  = 32'hA5A5A5A5;
    pstrb   = 4'hF;
    pprot   = 3'd1;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    total++;
    if (pready_a !== 1'b0 || err_cnt_a !== 8'd0) begin
      bad++;
      $display("FAIL rstmid got=r%b c%0d exp=r0 c0", pready_a, err_cnt_a);
    end
    preset  = 1'b0;
    psel_a  = 1'b0;
    penable = 1'b0;
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      bad++; $display("FAIL rstmid_mem got=%h e%b exp=0 e0", rd, err);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'd1, rd, err, n);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("FAIL rst_clear got=%h exp=0", rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    int          n1, n2;
    xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'd1, rd, err, n1);
    xfer(1, 1'b1, 32'h24, 32'h0BADC0DE, 4'hF, 3'd1, rd, err, n2);
    total++;
    if (n1 !== 1 || n2 !== 1) begin
      bad++; $display("FAIL b2b_len got=%0d/%0d exp=1/1", n1, n2);
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'd1, rd, err, n1);
    total++;
    if (rd !== 32'hCAFEF00D || n1 !== 1) begin
      bad++; $display("FAIL b2b_rd0 got=%h n%0d exp=cafef00d n1", rd, n1);
    end
    xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 3'd1, rd, err, n1);
    total++;
    if (rd !== 32'h0BADC0DE) begin
      bad++; $display("FAIL b2b_rd1 got=%h exp=0badc0de", rd);
    end
    idle();
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    logic        err;
    int          n;
    int          nerr;
    nerr = 0;
    for (int i = 0; i < 260; i++) begin
      xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 3'd1, rd, err, n);
      if (err === 1'b1) nerr++;
    end
    idle();
    total++;
    if (nerr !== 260) begin
      bad++; $display("FAIL sat_errs got=%0d exp=260", nerr);
    end
    total++;
    if (err_cnt_b !== 8'd255) begin
      bad++; $display("FAIL sat_cnt got=%0d exp=255", err_cnt_b);
    end
  endtask

  task automatic test_quiet_outputs();
    total++;
    if (leaks !== 0) begin
      bad++; $display("FAIL quiet got=%0d exp=0", leaks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_quiet_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
